// File: rtl/subcarrier_modulator.sv
// Slot-timed modulator: guard, active window (OOK or square subcarrier), tail.
// Build option: SUBCARRIER_MODULATOR_REPEAT_EN restarts frames back-to-back.
module subcarrier_modulator #(
  parameter int PRESCALE  = 50,
  parameter int CNT_W     = 16,
  parameter int ON_START  = 448,
  parameter int ON_END    = 6000,
  parameter int FRAME_LEN = 6400,
  parameter int HP_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             trigger_signal,
  input  logic             mode_sel,
  input  logic [HP_W-1:0]  half_period,
  output logic             output_signal,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] slot_count
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ON_START_C = CNT_W'(ON_START);
  localparam logic [CNT_W-1:0] ON_END_C = CNT_W'(ON_END);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    GUARD,
    ACTIVE,
    TAIL,
    DONE
  } state_t;

  state_t state_q, state_n;
  logic [PS_W-1:0] presc_q, presc_n;
  logic [CNT_W-1:0] slot_q, slot_n;
  logic [HP_W-1:0] phase_q, phase_n;
  logic [HP_W-1:0] hpm_q, hpm_n;
  logic mode_q, mode_n;
  logic out_q, out_n;
  logic done_q, done_n;
  logic busy_q, busy_n;

  logic tick;
  logic in_guard;
  logic in_active;
  logic is_last;

  assign tick = (presc_q == '0);
  assign in_guard = (slot_q <= ON_START_C);
  assign in_active = (slot_q > ON_START_C) && (slot_q <= ON_END_C);
  assign is_last = (slot_q == LAST_C);

  // State and datapath register; reset clears everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      slot_q  <= '0;
      phase_q <= '0;
      hpm_q   <= '0;
      mode_q  <= 1'b0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      presc_q <= presc_n;
      slot_q  <= slot_n;
      phase_q <= phase_n;
      hpm_q   <= hpm_n;
      mode_q  <= mode_n;
      out_q   <= out_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
    end
  end

  // Next state: slot position decides the region on every tick
  always_comb begin
    state_n = state_q;
    presc_n = presc_q;
    slot_n  = slot_q;
    phase_n = phase_q;
    hpm_n   = hpm_q;
    mode_n  = mode_q;
    out_n   = out_q;
    done_n  = 1'b0;
    if (!trigger_signal) begin
      state_n = IDLE;
      presc_n = '0;
      slot_n  = '0;
      phase_n = '0;
      out_n   = 1'b0;
    end else begin
      presc_n = (presc_q == PS_MAX) ? '0 : presc_q + PS_W'(1);
      if (tick && state_q != DONE) begin
        unique case (1'b1)
          in_guard: begin
            state_n = GUARD;
            out_n   = 1'b0;
          end
          in_active: begin
            state_n = ACTIVE;
            if (state_q != ACTIVE) begin
              mode_n  = mode_sel;
              hpm_n   = (half_period == '0) ? '0
                        : half_period - HP_W'(1);
              out_n   = 1'b1;
              phase_n = '0;
            end else if (!mode_q) begin
              out_n = 1'b1;
            end else if (phase_q == hpm_q) begin
              out_n   = ~out_q;
              phase_n = '0;
            end else begin
              phase_n = phase_q + HP_W'(1);
            end
          end
          default: begin
            state_n = TAIL;
            out_n   = 1'b0;
          end
        endcase
        if (is_last) begin
          done_n  = 1'b1;
          out_n   = 1'b0;
          phase_n = '0;
`ifdef SUBCARRIER_MODULATOR_REPEAT_EN
          slot_n  = '0;
          state_n = GUARD;
`else
          state_n = DONE;
`endif
        end else begin
          slot_n = slot_q + CNT_W'(1);
        end
      end
    end
    busy_n = (state_n != IDLE);
  end

  assign output_signal = out_q;
  assign busy = busy_q;
  assign frame_done = done_q;
  assign slot_count = slot_q;

endmodule

// File: tb/tb_subcarrier_modulator.sv
// Bench for subcarrier_modulator: directed frames plus randomized segments
// compared against a slot-arithmetic reference model.
module tb_subcarrier_modulator;

  localparam int P   = 2;
  localparam int ONS = 3;
  localparam int ONE = 7;
  localparam int FL  = 10;
  localparam int CW  = 16;
  localparam int HW  = 8;

  logic          clock;
  logic          reset;
  logic          trigger_signal;
  logic          mode_sel;
  logic [HW-1:0] half_period;
  logic          output_signal;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] slot_count;

  subcarrier_modulator #(
    .PRESCALE(P), .CNT_W(CW), .ON_START(ONS),
    .ON_END(ONE), .FRAME_LEN(FL), .HP_W(HW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .trigger_signal(trigger_signal),
    .mode_sel(mode_sel),
    .half_period(half_period),
    .output_signal(output_signal),
    .busy(busy),
    .frame_done(frame_done),
    .slot_count(slot_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int fails = 0;

  int k = -1;
  bit cap_mode;
  int cap_h = 1;
  bit e_out, e_busy, e_fd;
  int e_slot;

`ifdef SUBCARRIER_MODULATOR_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: k = triggered edges since start, n = index of latest tick
  task automatic model(input bit trg, input bit rst, input bit md,
                       input int hp);
    int n, m, j;
    bit tk, ended;
    if (rst || !trg) begin
      k = -1;
      e_out = 0; e_busy = 0; e_fd = 0; e_slot = 0;
    end else begin
      k++;
      n = k / P;
      tk = (k % P) == 0;
      m = REP ? (n % FL) : ((n < FL) ? n : FL - 1);
      ended = !REP && (n >= FL - 1);
      if (tk && !ended && m == ONS + 1) begin
        cap_mode = md;
        cap_h = (hp == 0) ? 1 : hp;
      end
      e_fd = tk && (m == FL - 1) && (REP || n == FL - 1);
      if (REP) e_slot = (m + 1) % FL;
      else e_slot = ended ? FL - 1 : n + 1;
      if (!ended && m > ONS && m <= ONE) begin
        j = m - ONS - 1;
        e_out = cap_mode ? (((j / cap_h) % 2) == 0) : 1'b1;
      end else begin
        e_out = 0;
      end
      e_busy = 1;
    end
  endtask

  task automatic step(input bit trg, input bit rst, input bit md,
                      input int hp);
    @(negedge clock);
    trigger_signal = trg;
    reset = rst;
    mode_sel = md;
    half_period = HW'(hp);
    @(posedge clock);
    model(trg, rst, md, hp);
    #1;
    chk("out", 32'(output_signal), 32'(e_out));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(frame_done), 32'(e_fd));
    chk("slot", 32'(slot_count), 32'(e_slot));
  endtask

  initial begin
    int len;
    int c;
    bit md;
    trigger_signal = 0;
    reset = 1;
    mode_sel = 0;
    half_period = 0;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("rst_out", 32'(output_signal), 32'd0);
    chk("rst_slot", 32'(slot_count), 32'd0);
    step(0, 0, 0, 0);

    // OOK frame; cycle c is observed after edge c-1
    for (int e = 0; e < 44; e++) begin
      step(1, 0, 0, 1);
      c = e + 1;
      chk("ook_win", 32'(output_signal),
          32'((c >= 9 && c <= 16) || (REP && c >= 29 && c <= 36)));
      chk("ook_fd", 32'(frame_done),
          32'(c == 19 || (REP && c == 39)));
    end
    if (!REP) begin
      chk("done_slot", 32'(slot_count), 32'(FL - 1));
      chk("done_busy", 32'(busy), 32'd1);
    end
    step(0, 0, 0, 0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Square subcarrier, half_period 1 and 0 give 1,1,0,0,...
    for (int h = 1; h >= 0; h--) begin
      for (int e = 0; e < 22; e++) begin
        step(1, 0, 1, h);
        c = e + 1;
        if (c >= 9 && c <= 16)
          chk("sq_pat", 32'(output_signal), 32'(((c - 9) / 2) % 2 == 0));
      end
      step(0, 0, 0, 0);
    end

    // Abort mid-window by dropping trigger at cycle 12
    for (int e = 0; e < 12; e++) step(1, 0, 0, 2);
    for (int e = 0; e < 4; e++) step(0, 0, 0, 2);
    chk("abort_slot", 32'(slot_count), 32'd0);

    // Reset pulse mid-frame with trigger held high
    for (int e = 0; e < 11; e++) step(1, 0, 1, 2);
    step(1, 1, 1, 2);
    chk("rstmid_out", 32'(output_signal), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    step(1, 0, 1, 2);
    chk("restart_slot", 32'(slot_count), 32'd1);
    for (int e = 0; e < 24; e++) step(1, 0, 1, 2);
    step(0, 0, 0, 0);

    // Randomized segments; mode/hp wiggle to prove mid-window sampling
    for (int s = 0; s < 30; s++) begin
      len = $urandom_range(1, 60);
      md = 1'($urandom_range(0, 1));
      for (int e = 0; e < len; e++) begin
        if ($urandom_range(0, 3) == 0) md = ~md;
        step(1, $urandom_range(0, 49) == 0, md, $urandom_range(0, 4));
      end
      step(0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/subcarrier_modulator.md
SUBCARRIER_MODULATOR -- requirements
Module: subcarrier_modulator

Interface
REQ-001 Parameter PRESCALE, default 50: clocks per slot tick; legal range 1 and above.
REQ-002 Parameter CNT_W, default 16: width of the slot counter.
REQ-003 Parameter ON_START, default 448: last slot of the leading guard.
REQ-004 Parameter ON_END, default 6000: last slot of the active window.
REQ-005 Parameter FRAME_LEN, default 6400: slots per frame; ON_START < ON_END < FRAME_LEN <= 2^CNT_W shall hold.
REQ-006 Parameter HP_W, default 8: width of half_period.
REQ-007 clock  input  1  single clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 trigger_signal  input  1  level enable; high runs the frame, low aborts it.
REQ-010 mode_sel  input  1  0 = on-off keying (constant 1 in window); 1 = square subcarrier in window.
REQ-011 half_period  input  HP_W  subcarrier half period in slot ticks; 0 is treated as 1.
REQ-012 output_signal  output  1  registered modulator drive.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  one-cycle pulse at frame end.
REQ-015 slot_count  output  CNT_W  current slot counter value.

Function
REQ-016 States: IDLE, GUARD, ACTIVE, TAIL, DONE; all outputs registered.
REQ-017 Prescaler: counts 0..PRESCALE-1 while trigger_signal high; a tick occurs on every cycle the prescaler is 0, including the first triggered cycle.
REQ-018 At each tick, with s = slot_count before increment: s <= ON_START gives GUARD, output 0; ON_START < s <= ON_END gives ACTIVE; s > ON_END gives TAIL, output 0; slot_count then increments.
REQ-019 ACTIVE, mode 0: output_signal = 1 on every tick.
REQ-020 ACTIVE, mode 1: first ACTIVE tick sets output 1 and clears the phase counter; output toggles on each tick where the phase counter equals max(half_period,1)-1, and the phase counter wraps to 0 there.
REQ-021 mode_sel and half_period are sampled on the GUARD-to-ACTIVE tick; mid-window changes are ignored until the next frame.
REQ-022 Tick with s = FRAME_LEN-1: frame_done is high for the following cycle only; end-of-frame handling follows REQ-028/029.
REQ-023 trigger_signal low on any cycle: next state IDLE; prescaler, slot_count and phase are 0; output_signal is 0; no frame_done pulse.
REQ-024 trigger_signal re-asserted from IDLE starts a new frame at slot 0 with a tick on the first cycle.
REQ-025 Slot arithmetic is unsigned CNT_W bits; slot_count never exceeds FRAME_LEN-1.

Reset
REQ-026 reset high, sampled on a rising edge, forces IDLE; output_signal, busy, frame_done = 0; slot_count, prescaler, phase = 0.
REQ-027 reset has priority over trigger_signal; reset mid-frame aborts the frame with no frame_done pulse.

Configuration
REQ-028 SUBCARRIER_MODULATOR_REPEAT_EN defined: at the final tick, slot_count wraps to 0 and the next frame starts in GUARD without a gap while trigger_signal stays high.
REQ-029 SUBCARRIER_MODULATOR_REPEAT_EN undefined: at the final tick, the block enters DONE with output 0, slot_count held at FRAME_LEN-1 and busy high; it leaves DONE only via trigger low or reset.

Verification (PRESCALE=2, ON_START=3, ON_END=7, FRAME_LEN=10, mode 0, unless noted)
REQ-030 trigger rises at cycle 0 -> output_signal high from cycle 9 through cycle 16 inclusive, 0 elsewhere; frame_done high at cycle 19 only.
REQ-031 mode 1, half_period=1 -> in-window output pattern 1,1,0,0,1,1,0,0 (cycles 9-16); half_period=0 gives the same pattern.
REQ-032 trigger dropped at cycle 12 -> output_signal 0 and slot_count 0 from cycle 13; busy low; frame_done never pulses.
REQ-033 reset pulsed at cycle 11 with trigger held high -> all outputs 0 at cycle 12; new frame restarts at slot 0 on the first cycle after reset deasserts.
REQ-034 REPEAT_EN on, trigger held 40 cycles -> frame_done pulses at cycles 19 and 39, output high at cycles 29-36; REPEAT_EN off -> after cycle 19, output 0, slot_count 9, busy 1 until trigger falls.
